// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane enable helper
// for the SRAM responder.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_B = 3'd0;
    localparam logic [2:0] HSIZE_H = 3'd1;
    localparam logic [2:0] HSIZE_W = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RAW  = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } slv_state_t;

    function automatic logic [3:0] be_gen(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] be;
        case (hsize)
            HSIZE_B: be = 4'b0001 << addr;
            HSIZE_H: be = 4'b0011 << {addr[1], 1'b0};
            HSIZE_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Single-port synchronous SRAM: byte-lane writes, one-cycle registered read.
// The read register only reloads on a read, so it holds across writes.
module ahb_sram_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [0:(2**AW)-1];

    // Array write by lane, registered read when no lane is written
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem_r[addr];
            end
        end
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder in front of a single-port SRAM: zero-wait writes, reads with
// configurable latency, one stall for a read that collides with a write data phase.
module ahb_lite_sram_slave #(
    parameter int          AW        = 12,
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          RD_WAIT   = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);
    import ahb_lite_pkg::*;

    localparam logic [31:0] SPAN      = 32'd1 << (AW + 2);
    localparam logic [1:0]  RD_WAIT_C = 2'(RD_WAIT);

    slv_state_t    state_r;
    logic [1:0]    cnt_r;
    logic [AW-1:0] addr_r;
    logic [3:0]    be_r;
    logic [31:0]   hrdata_r;
    logic          hreadyout_r;
    logic          hresp_r;

    logic [31:0]   offset_s;
    logic          accept_s;
    logic          err_s;
    logic [3:0]    be_s;
    logic          rd_done_s;
    logic          dec_ok_s;
    logic          take_s;
    slv_state_t    dec_s;
    slv_state_t    next_s;
    logic [1:0]    next_cnt_s;
    logic          mem_en_s;
    logic [3:0]    mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [31:0]   mem_rdata_s;
    logic          unused_s;

    assign unused_s = htrans[0];

    // Address-phase decode and the state the decode would lead to
    always_comb begin
        offset_s  = haddr - BASE_ADDR;
        accept_s  = hsel & hready & htrans[1];
        be_s      = be_gen(hsize, haddr[1:0]);
        err_s     = (hsize > HSIZE_W)
                  | ((hsize == HSIZE_H) & haddr[0])
                  | ((hsize == HSIZE_W) & (haddr[1:0] != 2'b00))
                  | (offset_s >= SPAN);
        rd_done_s = (state_r == ST_RD) && (cnt_r == 2'd0);
        dec_ok_s  = (state_r == ST_IDLE) || (state_r == ST_WR) ||
                    (state_r == ST_ERR2) || rd_done_s;
        take_s    = dec_ok_s & accept_s;
        if (!accept_s) begin
            dec_s = ST_IDLE;
        end else if (err_s) begin
            dec_s = ST_ERR1;
        end else if (hwrite) begin
            dec_s = ST_WR;
        end else if (state_r == ST_WR) begin
            dec_s = ST_RAW;
        end else begin
            dec_s = ST_RD;
        end
    end

    // Next-state selection; stalling states ignore the bus decode
    always_comb begin
        next_s     = state_r;
        next_cnt_s = cnt_r;
        case (state_r)
            ST_RAW: begin
                next_s     = ST_RD;
                next_cnt_s = RD_WAIT_C;
            end
            ST_ERR1: begin
                next_s = ST_ERR2;
            end
            ST_RD: begin
                if (cnt_r != 2'd0) begin
                    next_cnt_s = cnt_r - 2'd1;
                end else begin
                    next_s     = dec_s;
                    next_cnt_s = RD_WAIT_C;
                end
            end
            default: begin
                next_s     = dec_s;
                next_cnt_s = RD_WAIT_C;
            end
        endcase
    end

    // SRAM port arbitration: write data phase first, then a deferred read
    always_comb begin
        mem_en_s   = 1'b0;
        mem_we_s   = 4'b0000;
        mem_addr_s = addr_r;
        if (state_r == ST_WR) begin
            mem_en_s = 1'b1;
            mem_we_s = be_r;
        end else if (state_r == ST_RAW) begin
            mem_en_s = 1'b1;
        end else if (take_s && !err_s && !hwrite) begin
            mem_en_s   = 1'b1;
            mem_addr_s = offset_s[AW+1:2];
        end else begin
            mem_en_s = 1'b0;
        end
    end

    // FSM state, captured address phase and registered bus responses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 2'd0;
            addr_r      <= '0;
            be_r        <= 4'b0000;
            hrdata_r    <= 32'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r <= next_s;
            cnt_r   <= next_cnt_s;
            if (take_s) begin
                addr_r <= offset_s[AW+1:2];
                be_r   <= be_s;
            end
            if (rd_done_s) begin
                hrdata_r <= mem_rdata_s;
            end
            hreadyout_r <= !((next_s == ST_ERR1) || (next_s == ST_RAW) ||
                             ((next_s == ST_RD) && (next_cnt_s != 2'd0)));
            hresp_r     <= ((next_s == ST_ERR1) || (next_s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        end
    end

    assign hrdata    = rd_done_s ? mem_rdata_s : hrdata_r;
    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;

    ahb_sram_mem #(.AW(AW)) u_mem (
        .clk   (clk),
        .en    (mem_en_s),
        .we    (mem_we_s),
        .addr  (mem_addr_s),
        .wdata (hwdata),
        .rdata (mem_rdata_s)
    );

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: three slaves (RD_WAIT 0, 2, 3) share one master bus, each
// selected by its own hsel and stalled only by its own hreadyout.
module tb_ahb_lite_sram_slave;
    import ahb_lite_pkg::*;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel_b;
    logic [1:0]  sel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [2:0]  hsel_v;
    logic [2:0]  hrdy_v;
    logic [2:0]  hresp_v;
    logic [31:0] hrdata0, hrdata1, hrdata2;
    logic        hreadyout_m, hresp_m;
    logic [31:0] hrdata_m;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd;
    int          waits;
    logic        rf, rl;

    always #5 clk = ~clk;

    assign hsel_v[0]   = hsel_b && (sel == 2'd0);
    assign hsel_v[1]   = hsel_b && (sel == 2'd1);
    assign hsel_v[2]   = hsel_b && (sel == 2'd2);
    assign hreadyout_m = hrdy_v[sel];
    assign hresp_m     = hresp_v[sel];
    assign hrdata_m    = (sel == 2'd0) ? hrdata0 : (sel == 2'd1) ? hrdata1 : hrdata2;

    ahb_lite_sram_slave #(.AW(12), .BASE_ADDR(BASE), .RD_WAIT(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hrdy_v[0]),
        .hrdata(hrdata0), .hreadyout(hrdy_v[0]), .hresp(hresp_v[0]));

    ahb_lite_sram_slave #(.AW(12), .BASE_ADDR(BASE), .RD_WAIT(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hrdy_v[1]),
        .hrdata(hrdata1), .hreadyout(hrdy_v[1]), .hresp(hresp_v[1]));

    ahb_lite_sram_slave #(.AW(12), .BASE_ADDR(BASE), .RD_WAIT(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hrdy_v[2]),
        .hrdata(hrdata2), .hreadyout(hrdy_v[2]), .hresp(hresp_v[2]));

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic drive_addr(input logic wr, input logic [2:0] size, input logic [31:0] addr);
        hsel_b = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
    endtask

    task automatic drive_idle();
        hsel_b = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = HSIZE_W;
        haddr  = 32'd0;
    endtask

    // Runs one data phase from just after its accept edge to just after its completion edge
    task automatic wait_done(output logic [31:0] rdat, output int nw, output logic r_first, output logic r_last);
        nw      = 0;
        r_first = 1'b0;
        r_last  = 1'b0;
        rdat    = 32'd0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) r_first = hresp_m;
            if (hreadyout_m) begin
                rdat   = hrdata_m;
                r_last = hresp_m;
                @(posedge clk); #1;
                return;
            end
            nw++;
            @(posedge clk); #1;
        end
        check_val("dphase_timeout", {31'd0, hreadyout_m}, 32'd1);
    endtask

    task automatic single(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdat, output logic [31:0] rdat, output int nw,
                          output logic r_first, output logic r_last);
        drive_addr(wr, size, addr);
        @(posedge clk); #1;
        hwdata = wdat;
        drive_idle();
        wait_done(rdat, nw, r_first, r_last);
    endtask

    initial begin
        rstn   = 1'b0;
        sel    = 2'd0;
        hwdata = 32'd0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hready0", {31'd0, hrdy_v[0]}, 32'd1);
        check_val("rst_hresp0",  {31'd0, hresp_v[0]}, 32'd0);
        check_val("rst_hrdata0", hrdata0, 32'd0);
        check_val("rst_hready2", {31'd0, hrdy_v[2]}, 32'd1);
        check_val("rst_hrdata2", hrdata2, 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Word write immediately followed by a read of the same word
        drive_addr(1'b1, HSIZE_W, BASE + 32'h10);
        @(posedge clk); #1;
        hwdata = 32'hDEAD_BEEF;
        drive_addr(1'b0, HSIZE_W, BASE + 32'h10);
        wait_done(rd, waits, rf, rl);
        check_val("raw_wr_waits", waits, 32'd0);
        drive_idle();
        wait_done(rd, waits, rf, rl);
        check_val("raw_rd_waits", waits, 32'd1);
        check_val("raw_rd_data", rd, 32'hDEAD_BEEF);
        check_val("raw_rd_resp", {31'd0, rl}, 32'd0);

        // Sub-word writes over a zero word; junk in disabled lanes must be ignored
        single(1'b1, HSIZE_W, BASE + 32'h20, 32'h0000_0000, rd, waits, rf, rl);
        single(1'b1, HSIZE_B, BASE + 32'h21, 32'hFFFF_5AFF, rd, waits, rf, rl);
        single(1'b1, HSIZE_H, BASE + 32'h22, 32'h1234_FFFF, rd, waits, rf, rl);
        single(1'b0, HSIZE_W, BASE + 32'h20, 32'd0, rd, waits, rf, rl);
        check_val("subword_data", rd, 32'h1234_5A00);
        check_val("subword_waits", waits, 32'd0);
        @(negedge clk);
        check_val("hrdata_hold", hrdata0, 32'h1234_5A00);
        @(posedge clk); #1;

        // Error responses leave memory untouched
        single(1'b1, HSIZE_W, BASE, 32'hA5A5_A5A5, rd, waits, rf, rl);
        single(1'b0, HSIZE_W, BASE + 32'h2, 32'd0, rd, waits, rf, rl);
        check_val("mis_word_waits", waits, 32'd1);
        check_val("mis_word_err1", {31'd0, rf}, 32'd1);
        check_val("mis_word_err2", {31'd0, rl}, 32'd1);
        single(1'b1, HSIZE_H, BASE + 32'h3, 32'hFFFF_FFFF, rd, waits, rf, rl);
        check_val("mis_half_err", {waits[30:0], rl}, {31'd1, 1'b1});
        single(1'b1, HSIZE_W, BASE + 32'h4000, 32'hFFFF_FFFF, rd, waits, rf, rl);
        check_val("oor_high_err", {waits[30:0], rl}, {31'd1, 1'b1});
        single(1'b1, 3'd3, BASE, 32'hFFFF_FFFF, rd, waits, rf, rl);
        check_val("bad_size_err", {waits[30:0], rl}, {31'd1, 1'b1});
        drive_addr(1'b1, HSIZE_W, BASE - 32'h4);
        @(posedge clk); #1;
        hwdata = 32'hFFFF_FFFF;
        drive_addr(1'b0, HSIZE_W, BASE);
        wait_done(rd, waits, rf, rl);
        check_val("oor_low_err", {waits[30:0], rl}, {31'd1, 1'b1});
        drive_idle();
        wait_done(rd, waits, rf, rl);
        check_val("err2_accept_data", rd, 32'hA5A5_A5A5);
        check_val("err2_accept_resp", {waits[30:0], rl}, 32'd0);

        // Top word of the decoded range is legal
        single(1'b1, HSIZE_W, BASE + 32'h3FFC, 32'h600D_0001, rd, waits, rf, rl);
        single(1'b0, HSIZE_W, BASE + 32'h3FFC, 32'd0, rd, waits, rf, rl);
        check_val("top_word", rd, 32'h600D_0001);
        check_val("top_word_resp", {31'd0, rl}, 32'd0);

        // Back-to-back writes, then a colliding read, then write after read
        drive_addr(1'b1, HSIZE_W, BASE + 32'h30);
        @(posedge clk); #1;
        hwdata = 32'h1111_1111;
        drive_addr(1'b1, HSIZE_W, BASE + 32'h34);
        wait_done(rd, waits, rf, rl);
        check_val("b2b_wr1_waits", waits, 32'd0);
        hwdata = 32'h2222_2222;
        drive_addr(1'b0, HSIZE_W, BASE + 32'h30);
        wait_done(rd, waits, rf, rl);
        check_val("b2b_wr2_waits", waits, 32'd0);
        drive_addr(1'b0, HSIZE_W, BASE + 32'h34);
        wait_done(rd, waits, rf, rl);
        check_val("b2b_rd_data", rd, 32'h1111_1111);
        check_val("b2b_rd_waits", waits, 32'd1);
        drive_addr(1'b1, HSIZE_W, BASE + 32'h34);
        wait_done(rd, waits, rf, rl);
        check_val("rr_data", rd, 32'h2222_2222);
        check_val("rr_waits", waits, 32'd0);
        hwdata = 32'h3333_3333;
        drive_idle();
        wait_done(rd, waits, rf, rl);
        check_val("war_waits", waits, 32'd0);
        single(1'b0, HSIZE_W, BASE + 32'h34, 32'd0, rd, waits, rf, rl);
        check_val("war_data", rd, 32'h3333_3333);

        // BUSY, IDLE and deselected NONSEQ must not touch the SRAM
        for (int k = 0; k < 3; k++) begin
            hsel_b = (k != 2);
            htrans = (k == 0) ? HTRANS_BUSY : (k == 1) ? HTRANS_IDLE : HTRANS_NONSEQ;
            hwrite = 1'b1;
            hsize  = HSIZE_W;
            haddr  = BASE;
            @(posedge clk); #1;
            drive_idle();
            hwdata = 32'hFFFF_FFFF;
            @(negedge clk);
            check_val($sformatf("noxfer%0d_resp", k),
                      {30'd0, hrdy_v[0], hresp_v[0]}, {30'd0, 1'b1, 1'b0});
            check_val($sformatf("noxfer%0d_en", k), {31'd0, u_dut0.u_mem.en}, 32'd0);
            @(posedge clk); #1;
        end
        single(1'b0, HSIZE_W, BASE, 32'd0, rd, waits, rf, rl);
        check_val("noxfer_mem", rd, 32'hA5A5_A5A5);

        // RD_WAIT = 2 with a NONSEQ held during the stall
        sel = 2'd1;
        single(1'b1, HSIZE_W, BASE, 32'hCAFE_F00D, rd, waits, rf, rl);
        single(1'b1, HSIZE_W, BASE + 32'h8, 32'h0BAD_F00D, rd, waits, rf, rl);
        drive_addr(1'b0, HSIZE_W, BASE);
        @(posedge clk); #1;
        drive_addr(1'b0, HSIZE_W, BASE + 32'h8);
        wait_done(rd, waits, rf, rl);
        check_val("rw2_waits", waits, 32'd2);
        check_val("rw2_data", rd, 32'hCAFE_F00D);
        drive_idle();
        wait_done(rd, waits, rf, rl);
        check_val("rw2_pipe_waits", waits, 32'd2);
        check_val("rw2_pipe_data", rd, 32'h0BAD_F00D);

        // RD_WAIT = 3, reset asserted in the second wait cycle
        sel = 2'd2;
        single(1'b1, HSIZE_W, BASE + 32'h40, 32'h7777_8888, rd, waits, rf, rl);
        single(1'b0, HSIZE_W, BASE + 32'h40, 32'd0, rd, waits, rf, rl);
        check_val("rw3_waits", waits, 32'd3);
        check_val("rw3_data", rd, 32'h7777_8888);
        drive_addr(1'b0, HSIZE_W, BASE + 32'h40);
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #2;
        check_val("rw3_stall_pre_rst", {31'd0, hrdy_v[2]}, 32'd0);
        rstn = 1'b0;
        #1;
        check_val("rst_mid_hready", {31'd0, hrdy_v[2]}, 32'd1);
        check_val("rst_mid_hresp", {31'd0, hresp_v[2]}, 32'd0);
        check_val("rst_mid_hrdata", hrdata2, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        single(1'b0, HSIZE_W, BASE + 32'h40, 32'd0, rd, waits, rf, rl);
        check_val("post_rst_data", rd, 32'h7777_8888);
        check_val("post_rst_waits", waits, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
